// File: rtl/wormhole_xbar.sv
// NUM_PORTS x NUM_PORTS wormhole crossbar: per-output round-robin arbitration, packet locking, registered outputs.
// Define SWITCH_STATS_EN to build the saturating orphan-drop counter on o_drop_cnt.
module wormhole_xbar #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 32,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        i_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0] i_flit,
    input  logic [NUM_PORTS*2-1:0]      i_type,
    input  logic [NUM_PORTS*PORT_W-1:0] i_dest,
    output logic [NUM_PORTS-1:0]        o_in_ready,
    output logic [NUM_PORTS-1:0]        o_valid,
    output logic [NUM_PORTS*FLIT_W-1:0] o_flit,
    output logic [NUM_PORTS*2-1:0]      o_type,
    input  logic [NUM_PORTS-1:0]        i_out_ready,
    output logic [15:0]                 o_drop_cnt
);
    localparam int IW = PORT_W + 1;

    logic [FLIT_W-1:0]              in_flit [NUM_PORTS];
    logic [1:0]                     in_type [NUM_PORTS];
    logic [PORT_W-1:0]              in_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]           in_head;
    logic [NUM_PORTS-1:0]           in_tail;
    logic [NUM_PORTS-1:0]           dest_bad;
    logic [NUM_PORTS-1:0]           locked_vec;
    logic [NUM_PORTS*PORT_W-1:0]    owner_flat;
    logic [NUM_PORTS*NUM_PORTS-1:0] grant_flat;
    logic [NUM_PORTS-1:0]           bound;
    logic [NUM_PORTS-1:0]           granted;
    logic [NUM_PORTS-1:0]           orphan;

    function automatic logic [PORT_W-1:0] rr_inc(input logic [PORT_W-1:0] p);
        return (32'(p) == NUM_PORTS - 1) ? '0 : p + PORT_W'(1);
    endfunction

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        assign in_flit[gi]  = i_flit[gi*FLIT_W +: FLIT_W];
        assign in_type[gi]  = i_type[gi*2 +: 2];
        assign in_dest[gi]  = i_dest[gi*PORT_W +: PORT_W];
        // Type bit 0 marks HEAD/HEAD_TAIL, bit 1 marks TAIL/HEAD_TAIL.
        assign in_head[gi]  = in_type[gi][0];
        assign in_tail[gi]  = in_type[gi][1];
        assign dest_bad[gi] = 32'(in_dest[gi]) >= NUM_PORTS;
    end

    always_comb begin
        bound = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (locked_vec[o] && owner_flat[o*PORT_W +: PORT_W] == PORT_W'(i)) begin
                    bound[i] = 1'b1;
                end
            end
        end
    end

    // A bound input only ever feeds its locked output, so any head it presents is a protocol error.
    always_comb begin
        granted = '0;
        orphan  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                granted[i] = granted[i] | grant_flat[o*NUM_PORTS + i];
            end
            orphan[i] = i_valid[i] && (bound[i] ? in_head[i] : (!in_head[i] || dest_bad[i]));
        end
    end

    assign o_in_ready = rst_n ? (granted | orphan) : '0;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
        logic                 locked_reg;
        logic                 locked_next;
        logic [PORT_W-1:0]    owner_reg;
        logic [PORT_W-1:0]    owner_next;
        logic [PORT_W-1:0]    rr_reg;
        logic [PORT_W-1:0]    rr_next;
        logic [PORT_W-1:0]    src;
        logic [IW-1:0]        idx;
        logic                 valid_reg;
        logic [FLIT_W-1:0]    flit_reg;
        logic [1:0]           type_reg;
        logic [NUM_PORTS-1:0] cand;
        logic [NUM_PORTS-1:0] grant;
        logic                 can_load;
        logic                 found;
        logic                 xfer;

        assign can_load = !valid_reg || i_out_ready[gi];

        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[i] = i_valid[i] && in_head[i] && !bound[i] && (in_dest[i] == PORT_W'(gi));
            end
        end

        always_comb begin
            found       = 1'b0;
            src         = owner_reg;
            idx         = '0;
            grant       = '0;
            xfer        = 1'b0;
            locked_next = locked_reg;
            owner_next  = owner_reg;
            rr_next     = rr_reg;
            if (locked_reg) begin
                if (i_valid[owner_reg] && !in_head[owner_reg] && can_load) begin
                    xfer             = 1'b1;
                    grant[owner_reg] = 1'b1;
                    if (in_tail[owner_reg]) begin
                        locked_next = 1'b0;
                        rr_next     = rr_inc(owner_reg);
                    end
                end
            end else begin
                // First candidate at or after rr, wrapping.
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = {1'b0, rr_reg} + IW'(k);
                    if (idx >= IW'(NUM_PORTS)) begin
                        idx = idx - IW'(NUM_PORTS);
                    end
                    if (!found && cand[idx[PORT_W-1:0]]) begin
                        found = 1'b1;
                        src   = idx[PORT_W-1:0];
                    end
                end
                if (found && can_load) begin
                    xfer       = 1'b1;
                    grant[src] = 1'b1;
                    if (in_tail[src]) begin
                        rr_next = rr_inc(src);
                    end else begin
                        locked_next = 1'b1;
                        owner_next  = src;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                locked_reg <= 1'b0;
                owner_reg  <= '0;
                rr_reg     <= '0;
                valid_reg  <= 1'b0;
                flit_reg   <= '0;
                type_reg   <= '0;
            end else begin
                locked_reg <= locked_next;
                owner_reg  <= owner_next;
                rr_reg     <= rr_next;
                if (xfer) begin
                    valid_reg <= 1'b1;
                    flit_reg  <= in_flit[src];
                    type_reg  <= in_type[src];
                end else if (i_out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end
        end

        assign locked_vec[gi]                         = locked_reg;
        assign owner_flat[gi*PORT_W +: PORT_W]        = owner_reg;
        assign grant_flat[gi*NUM_PORTS +: NUM_PORTS]  = grant;
        assign o_valid[gi]                            = valid_reg;
        assign o_flit[gi*FLIT_W +: FLIT_W]            = flit_reg;
        assign o_type[gi*2 +: 2]                      = type_reg;
    end

`ifdef SWITCH_STATS_EN
    logic [4:0]  drop_inc;
    logic [16:0] drop_sum;
    logic [15:0] drop_cnt_reg;

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            drop_inc = drop_inc + 5'(orphan[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign o_drop_cnt = drop_cnt_reg;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_wormhole_xbar.sv
// Self-checking bench for wormhole_xbar: vector table, hand-written wormhole/backpressure/reset sequences,
// and randomized traffic checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_wormhole_xbar;
    localparam int N  = 5;
    localparam int W  = 32;
    localparam int PW = 3;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;
`ifdef SWITCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   i_valid;
    logic [N*W-1:0] i_flit;
    logic [N*2-1:0] i_type;
    logic [N*PW-1:0] i_dest;
    logic [N-1:0]   o_in_ready;
    logic [N-1:0]   o_valid;
    logic [N*W-1:0] o_flit;
    logic [N*2-1:0] o_type;
    logic [N-1:0]   i_out_ready;
    logic [15:0]    o_drop_cnt;

    logic          tv [N];
    logic [1:0]    tt [N];
    logic [PW-1:0] td [N];
    logic [W-1:0]  tf [N];
    logic          tr [N];

    wormhole_xbar #(.NUM_PORTS(N), .FLIT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_flit     (i_flit),
        .i_type     (i_type),
        .i_dest     (i_dest),
        .o_in_ready (o_in_ready),
        .o_valid    (o_valid),
        .o_flit     (o_flit),
        .o_type     (o_type),
        .i_out_ready(i_out_ready),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        i_valid     = '0;
        i_type      = '0;
        i_dest      = '0;
        i_flit      = '0;
        i_out_ready = '0;
        for (int i = 0; i < N; i++) begin
            i_valid[i]         = tv[i];
            i_type[i*2 +: 2]   = tt[i];
            i_dest[i*PW +: PW] = td[i];
            i_flit[i*W +: W]   = tf[i];
            i_out_ready[i]     = tr[i];
        end
    end

    // Reference model: owner = -1 means the output is free.
    int           m_owner [N];
    int           m_rr    [N];
    logic         m_ov    [N];
    logic [W-1:0] m_of    [N];
    logic [1:0]   m_ot    [N];
    int           m_win   [N];
    int           m_drop;
    int           m_orph;
    logic [N-1:0] m_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [N-1:0]          valid;
        logic [N-1:0][1:0]     typ;
        logic [N-1:0][PW-1:0]  dest;
        logic [N-1:0]          exp_ready;
        logic [N-1:0]          exp_ovalid;
        logic [15:0]           exp_drop;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_head(input logic [1:0] t);
        return (t == T_HEAD) || (t == T_HT);
    endfunction

    function automatic void model_reset();
        for (int o = 0; o < N; o++) begin
            m_owner[o] = -1;
            m_rr[o]    = 0;
            m_ov[o]    = 1'b0;
            m_of[o]    = '0;
            m_ot[o]    = '0;
            m_win[o]   = -1;
        end
        m_drop = 0;
        m_orph = 0;
    endfunction

    function automatic void model_eval();
        bit bound [N];
        for (int i = 0; i < N; i++) bound[i] = 1'b0;
        for (int o = 0; o < N; o++) if (m_owner[o] >= 0) bound[m_owner[o]] = 1'b1;
        m_ready = '0;
        m_orph  = 0;
        for (int o = 0; o < N; o++) begin
            bit can;
            can      = !m_ov[o] || tr[o];
            m_win[o] = -1;
            if (can) begin
                if (m_owner[o] >= 0) begin
                    if (tv[m_owner[o]] && !is_head(tt[m_owner[o]])) m_win[o] = m_owner[o];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_rr[o] + k) % N;
                        if (m_win[o] < 0 && tv[i] && is_head(tt[i]) && !bound[i] && int'(td[i]) == o)
                            m_win[o] = i;
                    end
                end
            end
            if (m_win[o] >= 0) m_ready[m_win[o]] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (tv[i]) begin
                bit orph;
                orph = bound[i] ? is_head(tt[i]) : (!is_head(tt[i]) || int'(td[i]) >= N);
                if (orph) begin
                    m_ready[i] = 1'b1;
                    m_orph++;
                end
            end
        end
    endfunction

    function automatic void model_commit();
        for (int o = 0; o < N; o++) begin
            if (m_win[o] >= 0) begin
                int w;
                w       = m_win[o];
                m_ov[o] = 1'b1;
                m_of[o] = tf[w];
                m_ot[o] = tt[w];
                if (m_owner[o] >= 0) begin
                    if (tt[w] == T_TAIL) begin
                        m_owner[o] = -1;
                        m_rr[o]    = (w + 1) % N;
                    end
                end else if (tt[w] == T_HEAD) begin
                    m_owner[o] = w;
                end else begin
                    m_rr[o] = (w + 1) % N;
                end
            end else if (tr[o]) begin
                m_ov[o] = 1'b0;
            end
        end
        if (STATS) m_drop = (m_drop + m_orph > 65535) ? 65535 : m_drop + m_orph;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag);
        logic [N-1:0]   ev;
        logic [N*W-1:0] ef;
        logic [N*2-1:0] et;
        #2;
        model_eval();
        chk({tag, ".in_ready"}, o_in_ready, m_ready);
        @(posedge clk);
        #1;
        model_commit();
        for (int i = 0; i < N; i++) begin
            ev[i]          = m_ov[i];
            ef[i*W +: W]   = m_of[i];
            et[i*2 +: 2]   = m_ot[i];
        end
        chk({tag, ".o_valid"}, o_valid, ev);
        chk({tag, ".o_flit"}, o_flit, ef);
        chk({tag, ".o_type"}, o_type, et);
        chk({tag, ".drop"}, o_drop_cnt, m_drop);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0;
            tt[i] = T_BODY;
            td[i] = '0;
            tf[i] = '0;
            tr[i] = 1'b1;
        end
    endtask

    task automatic set_in(input int i, input logic [1:0] t, input int d, input logic [W-1:0] f);
        tv[i] = 1'b1;
        tt[i] = t;
        td[i] = PW'(d);
        tf[i] = f;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_valid"}, o_valid, '0);
        chk({tag, ".rst_in_ready"}, o_in_ready, '0);
        chk({tag, ".rst_drop"}, o_drop_cnt, '0);
        chk({tag, ".rst_flit"}, o_flit, '0);
        chk({tag, ".rst_type"}, o_type, '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] %s: reset applied", tag);
    endtask

    initial begin
        vecs[0] = '{valid: 5'b00001, typ: {T_BODY, T_BODY, T_BODY, T_BODY, T_HT},
                    dest: {3'd0, 3'd0, 3'd0, 3'd0, 3'd3}, exp_ready: 5'b00001, exp_ovalid: 5'b01000, exp_drop: 16'd0};
        vecs[1] = '{valid: 5'b11111, typ: {T_HT, T_HT, T_HT, T_HT, T_HT},
                    dest: {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, exp_ready: 5'b11111, exp_ovalid: 5'b11111, exp_drop: 16'd0};
        vecs[2] = '{valid: 5'b01000, typ: {T_BODY, T_BODY, T_BODY, T_BODY, T_BODY},
                    dest: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, exp_ready: 5'b01000, exp_ovalid: 5'b00000, exp_drop: 16'd1};
        vecs[3] = '{valid: 5'b01000, typ: {T_BODY, T_HEAD, T_BODY, T_BODY, T_BODY},
                    dest: {3'd0, 3'd7, 3'd0, 3'd0, 3'd0}, exp_ready: 5'b01000, exp_ovalid: 5'b00000, exp_drop: 16'd2};
        vecs[4] = '{valid: 5'b10010, typ: {T_HT, T_BODY, T_BODY, T_HT, T_BODY},
                    dest: {3'd2, 3'd0, 3'd0, 3'd2, 3'd0}, exp_ready: 5'b10000, exp_ovalid: 5'b00100, exp_drop: 16'd2};
        vecs[5] = '{valid: 5'b10010, typ: {T_HT, T_BODY, T_BODY, T_HT, T_BODY},
                    dest: {3'd2, 3'd0, 3'd0, 3'd2, 3'd0}, exp_ready: 5'b00010, exp_ovalid: 5'b00100, exp_drop: 16'd2};
        vecs[6] = '{valid: 5'b10010, typ: {T_HT, T_BODY, T_BODY, T_HT, T_BODY},
                    dest: {3'd2, 3'd0, 3'd0, 3'd2, 3'd0}, exp_ready: 5'b10000, exp_ovalid: 5'b00100, exp_drop: 16'd2};
        vecs[7] = '{valid: 5'b10010, typ: {T_HT, T_BODY, T_BODY, T_HT, T_BODY},
                    dest: {3'd2, 3'd0, 3'd0, 3'd2, 3'd0}, exp_ready: 5'b00010, exp_ovalid: 5'b00100, exp_drop: 16'd2};
        vecs[8] = '{valid: 5'b00011, typ: {T_BODY, T_BODY, T_BODY, T_TAIL, T_HT},
                    dest: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, exp_ready: 5'b00011, exp_ovalid: 5'b00001, exp_drop: 16'd3};

        rst_n = 1'b0;
        idle_inputs();
        set_in(0, T_HT, 0, 32'h1234_5678);
        @(negedge clk);
        apply_reset("init");
        idle_inputs();

        // Vector table, applied back to back from the post-reset state.
        for (int e = 0; e < 9; e++) begin
            idle_inputs();
            for (int i = 0; i < N; i++) begin
                tv[i] = vecs[e].valid[i];
                tt[i] = vecs[e].typ[i];
                td[i] = vecs[e].dest[i];
                tf[i] = 32'hA5A5_0001 + 32'(e << 8) + 32'(i << 4);
            end
            #1;
            chk($sformatf("vec%0d.ready", e), o_in_ready, vecs[e].exp_ready);
            step($sformatf("vec%0d", e));
            chk($sformatf("vec%0d.ovalid", e), o_valid, vecs[e].exp_ovalid);
            chk($sformatf("vec%0d.drop", e), o_drop_cnt, STATS ? vecs[e].exp_drop : 16'd0);
            if (e == 0) chk("vec0.payload", o_flit[3*W +: W], 32'hA5A5_0001);
            $display("[TB] vec %0d: in_ready=%b o_valid=%b drop=%0d", e, vecs[e].exp_ready, o_valid, o_drop_cnt);
        end

        // Wormhole lock with a 3-cycle stall mid-packet; input 2 contends for the same output.
        idle_inputs();
        @(negedge clk);
        apply_reset("pre_wormhole");
        idle_inputs();
        set_in(0, T_HEAD, 1, 32'h1000_0000);
        set_in(2, T_HEAD, 1, 32'h2000_0000);
        #1 chk("wh.h.ready", o_in_ready, 5'b00001);
        step("wh.h");
        chk("wh.h.flit", o_flit[1*W +: W], 32'h1000_0000);
        $display("[TB] wormhole: head from input 0 on output 1");
        set_in(0, T_BODY, 0, 32'h1000_0001);
        #1 chk("wh.b1.ready", o_in_ready, 5'b00001);
        step("wh.b1");
        chk("wh.b1.flit", o_flit[1*W +: W], 32'h1000_0001);
        set_in(0, T_BODY, 0, 32'h1000_0002);
        tr[1] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1 chk($sformatf("wh.stall%0d.ready", s), o_in_ready, 5'b00000);
            step($sformatf("wh.stall%0d", s));
            chk($sformatf("wh.stall%0d.flit", s), o_flit[1*W +: W], 32'h1000_0001);
            chk($sformatf("wh.stall%0d.valid", s), o_valid[1], 1'b1);
            $display("[TB] wormhole: stall cycle %0d", s);
        end
        tr[1] = 1'b1;
        #1 chk("wh.b2.ready", o_in_ready, 5'b00001);
        step("wh.b2");
        chk("wh.b2.flit", o_flit[1*W +: W], 32'h1000_0002);
        set_in(0, T_TAIL, 0, 32'h1000_0003);
        #1 chk("wh.t.ready", o_in_ready, 5'b00001);
        step("wh.t");
        chk("wh.t.flit", o_flit[1*W +: W], 32'h1000_0003);
        chk("wh.t.type", o_type[1*2 +: 2], T_TAIL);
        tv[0] = 1'b0;
        #1 chk("wh.next.ready", o_in_ready, 5'b00100);
        step("wh.next");
        chk("wh.next.flit", o_flit[1*W +: W], 32'h2000_0000);
        $display("[TB] wormhole: input 2 head granted after tail");

        // Reset while input 2 owns output 1: its body becomes an orphan afterwards.
        set_in(2, T_BODY, 0, 32'h2000_0001);
        apply_reset("midpkt");
        #1 chk("midpkt.orphan.ready", o_in_ready, 5'b00100);
        step("midpkt.orphan");
        chk("midpkt.orphan.valid", o_valid, 5'b00000);
        $display("[TB] midpkt: post-reset body discarded");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                tv[i] = ($urandom_range(0, 9) < 7);
                tt[i] = 2'($urandom_range(0, 3));
                td[i] = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
                tf[i] = $urandom;
                tr[i] = ($urandom_range(0, 3) != 0);
            end
            step("rand");
        end
        $display("[TB] random: 3000 cycles applied, drop=%0d", o_drop_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
